// File: rtl/issue_stage.sv
// Issue stage: resolves source operands (register file plus writeback bypass),
// tracks pending destinations in a 32-entry scoreboard, and holds one issued instruction.
module issue_stage (
  input  logic        clk_i,
  input  logic        rst_ni,
  // decoded instruction (decoupled in)
  input  logic        decoded_valid_i,
  output logic        decoded_ready_o,
  input  logic [31:0] decoded_pc_i,
  input  logic [7:0]  decoded_op_i,
  input  logic [4:0]  decoded_rd_i,
  input  logic [4:0]  decoded_rs1_i,
  input  logic [4:0]  decoded_rs2_i,
  input  logic [31:0] decoded_imm_i,
  // issued instruction (decoupled out)
  output logic        issued_valid_o,
  input  logic        issued_ready_i,
  output logic [31:0] issued_pc_o,
  output logic [7:0]  issued_op_o,
  output logic [4:0]  issued_rd_o,
  output logic [4:0]  issued_rs1_o,
  output logic [4:0]  issued_rs2_o,
  output logic [31:0] issued_imm_o,
  output logic [31:0] issued_rs1_val_o,
  output logic [31:0] issued_rs2_val_o,
  // register file read ports
  output logic [4:0]  rf_rs1_idx_o,
  input  logic [31:0] rf_rs1_val_i,
  output logic [4:0]  rf_rs2_idx_o,
  input  logic [31:0] rf_rs2_val_i,
  // writeback
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_idx_i,
  input  logic [31:0] wb_rd_val_i,
  input  logic        flush_i,
  output logic [31:0] busy_o
);

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
  } instr_t;

  slot_state_e state_q, state_d;
  instr_t      slot_q, slot_d;
  logic [31:0] busy_q, busy_d;

  logic        fwd1, fwd2, rdy1, rdy2, waw, hazard, space, accept;
  logic [31:0] op1, op2;

  always_comb begin
    fwd1 = wb_valid_i && (wb_rd_idx_i == decoded_rs1_i) && (decoded_rs1_i != 5'd0);
    fwd2 = wb_valid_i && (wb_rd_idx_i == decoded_rs2_i) && (decoded_rs2_i != 5'd0);

    op1 = '0;
    if (decoded_rs1_i != 5'd0) op1 = fwd1 ? wb_rd_val_i : rf_rs1_val_i;
    op2 = '0;
    if (decoded_rs2_i != 5'd0) op2 = fwd2 ? wb_rd_val_i : rf_rs2_val_i;

    rdy1 = (decoded_rs1_i == 5'd0) || !busy_q[decoded_rs1_i] || fwd1;
    rdy2 = (decoded_rs2_i == 5'd0) || !busy_q[decoded_rs2_i] || fwd2;
    // WAW is lifted when the pending write to rd retires in this same cycle
    waw  = (decoded_rd_i != 5'd0) && busy_q[decoded_rd_i] &&
           !(wb_valid_i && (wb_rd_idx_i == decoded_rd_i));

    hazard = !rdy1 || !rdy2 || waw;
    space  = (state_q == SLOT_EMPTY) || issued_ready_i;
    decoded_ready_o = space && !hazard && !flush_i;
    accept = decoded_valid_i && decoded_ready_o;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
      SLOT_FULL:  if (!accept && issued_ready_i) state_d = SLOT_EMPTY;
    endcase
    if (flush_i) state_d = SLOT_EMPTY;

    slot_d = slot_q;
    if (accept) begin
      slot_d.pc      = decoded_pc_i;
      slot_d.op      = decoded_op_i;
      slot_d.rd      = decoded_rd_i;
      slot_d.rs1     = decoded_rs1_i;
      slot_d.rs2     = decoded_rs2_i;
      slot_d.imm     = decoded_imm_i;
      slot_d.rs1_val = op1;
      slot_d.rs2_val = op2;
    end

    // clear before set so a same-cycle set wins
    busy_d = busy_q;
    if (wb_valid_i && (wb_rd_idx_i != 5'd0)) busy_d[wb_rd_idx_i] = 1'b0;
    if (accept && (decoded_rd_i != 5'd0))    busy_d[decoded_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
    if (flush_i) busy_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SLOT_EMPTY;
      slot_q  <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      busy_q  <= busy_d;
    end
  end

  assign issued_valid_o   = (state_q == SLOT_FULL);
  assign issued_pc_o      = slot_q.pc;
  assign issued_op_o      = slot_q.op;
  assign issued_rd_o      = slot_q.rd;
  assign issued_rs1_o     = slot_q.rs1;
  assign issued_rs2_o     = slot_q.rs2;
  assign issued_imm_o     = slot_q.imm;
  assign issued_rs1_val_o = slot_q.rs1_val;
  assign issued_rs2_val_o = slot_q.rs2_val;
  assign rf_rs1_idx_o     = decoded_rs1_i;
  assign rf_rs2_idx_o     = decoded_rs2_i;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_issue_stage.sv
// Self-checking bench for issue_stage: directed scenarios then random traffic,
// compared against a queue-based model of the output slot and scoreboard.
module tb_issue_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] v1;
    logic [31:0] v2;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        d_valid = 1'b0, i_ready = 1'b0, wbv = 1'b0, flush = 1'b0;
  logic [31:0] d_pc = '0, d_imm = '0, wbval = '0;
  logic [7:0]  d_op = '0;
  logic [4:0]  d_rd = '0, d_rs1 = '0, d_rs2 = '0, wbi = '0;

  logic        decoded_ready, issued_valid;
  logic [31:0] iss_pc, iss_imm, iss_v1, iss_v2, busy, rf1, rf2;
  logic [7:0]  iss_op;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2, rf1_idx, rf2_idx;

  logic [31:0] rf_m [32];
  assign rf1 = rf_m[rf1_idx];
  assign rf2 = rf_m[rf2_idx];

  issue_stage dut (
    .clk_i(clk), .rst_ni(rst_n),
    .decoded_valid_i(d_valid), .decoded_ready_o(decoded_ready),
    .decoded_pc_i(d_pc), .decoded_op_i(d_op), .decoded_rd_i(d_rd),
    .decoded_rs1_i(d_rs1), .decoded_rs2_i(d_rs2), .decoded_imm_i(d_imm),
    .issued_valid_o(issued_valid), .issued_ready_i(i_ready),
    .issued_pc_o(iss_pc), .issued_op_o(iss_op), .issued_rd_o(iss_rd),
    .issued_rs1_o(iss_rs1), .issued_rs2_o(iss_rs2), .issued_imm_o(iss_imm),
    .issued_rs1_val_o(iss_v1), .issued_rs2_val_o(iss_v2),
    .rf_rs1_idx_o(rf1_idx), .rf_rs1_val_i(rf1),
    .rf_rs2_idx_o(rf2_idx), .rf_rs2_val_i(rf2),
    .wb_valid_i(wbv), .wb_rd_idx_i(wbi), .wb_rd_val_i(wbval),
    .flush_i(flush), .busy_o(busy)
  );

  int   checks = 0;
  int   errors = 0;
  bit   m_busy [32];
  ins_t mq [$];
  int   popped = 0;
  logic last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  function automatic logic wb_hits(input logic [4:0] r);
    return wbv && (wbi == r) && (r != 5'd0);
  endfunction

  function automatic logic [31:0] opval(input logic [4:0] r);
    if (r == 5'd0)  return 32'd0;
    if (wb_hits(r)) return wbval;
    return rf_m[r];
  endfunction

  function automatic logic src_ok(input logic [4:0] r);
    return (r == 5'd0) || !m_busy[r] || wb_hits(r);
  endfunction

  function automatic logic [31:0] busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_clear();
    mq.delete();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
  endtask

  task automatic check_state();
    chk("issued_valid", {31'd0, issued_valid}, {31'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("issued_pc",  iss_pc,  mq[0].pc);
      chk("issued_op",  {24'd0, iss_op}, {24'd0, mq[0].op});
      chk("issued_rd",  {27'd0, iss_rd}, {27'd0, mq[0].rd});
      chk("issued_rs",  {22'd0, iss_rs1, iss_rs2}, {22'd0, mq[0].rs1, mq[0].rs2});
      chk("issued_imm", iss_imm, mq[0].imm);
      chk("issued_rs1_val", iss_v1, mq[0].v1);
      chk("issued_rs2_val", iss_v2, mq[0].v2);
    end
    chk("busy", busy, busy_vec());
  endtask

  // One clock: check combinational outputs, advance model, check registered state.
  task automatic cyc();
    logic exp_rdy;
    ins_t ni;
    #3;
    exp_rdy = (mq.size() == 0 || i_ready) && src_ok(d_rs1) && src_ok(d_rs2) &&
              !(d_rd != 5'd0 && m_busy[d_rd] && !(wbv && wbi == d_rd)) && !flush;
    chk("decoded_ready", {31'd0, decoded_ready}, {31'd0, exp_rdy});
    chk("rf_idx", {22'd0, rf1_idx, rf2_idx}, {22'd0, d_rs1, d_rs2});
    ni = '{pc: d_pc, op: d_op, rd: d_rd, rs1: d_rs1, rs2: d_rs2, imm: d_imm,
           v1: opval(d_rs1), v2: opval(d_rs2)};
    last_acc = d_valid && exp_rdy;
    if (flush) model_clear();
    else begin
      if (mq.size() != 0 && i_ready) begin
        void'(mq.pop_front());
        popped++;
      end
      if (wbv && wbi != 5'd0) m_busy[wbi] = 1'b0;
      if (last_acc) begin
        mq.push_back(ni);
        if (d_rd != 5'd0) m_busy[d_rd] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic set_ins(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
    d_valid = 1'b1; d_rd = rd; d_rs1 = rs1; d_rs2 = rs2; d_imm = imm;
    d_pc = d_pc + 32'd4; d_op = d_op + 8'd1;
  endtask

  task automatic idle();
    d_valid = 1'b0; wbv = 1'b0; flush = 1'b0;
  endtask

  task automatic flush_cycle();
    idle(); flush = 1'b1; cyc(); flush = 1'b0;
  endtask

  initial begin
    int base;
    bit tog;
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    model_clear();

    // reset
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_ready", {31'd0, decoded_ready}, 32'd1);
    chk("reset_valid", {31'd0, issued_valid}, 32'd0);
    chk("reset_busy", busy, 32'd0);
    chk("reset_slot", iss_pc ^ iss_imm ^ iss_v1 ^ iss_v2, 32'd0);

    // addi x1,x0,5 then writeback x1
    i_ready = 1'b1;
    set_ins(5'd1, 5'd0, 5'd0, 32'd5);
    cyc();
    chk("addi_busy", busy, 32'h2);
    chk("addi_rs1_val", iss_v1, 32'd0);
    idle(); wbv = 1'b1; wbi = 5'd1; wbval = 32'd5;
    cyc();
    chk("addi_wb_busy", busy, 32'h0);

    // add x3,x1,x2 waiting on x1, accepted via bypass
    idle();
    set_ins(5'd1, 5'd0, 5'd0, 32'd7);
    cyc();
    set_ins(5'd3, 5'd1, 5'd2, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("raw_stall", {31'd0, last_acc}, 32'd0);
    end
    wbv = 1'b1; wbi = 5'd1; wbval = 32'h1234;
    cyc();
    chk("raw_bypass_accept", {31'd0, last_acc}, 32'd1);
    chk("raw_bypass_val", iss_v1, 32'h1234);
    flush_cycle();

    // 8 independent ops with issued_ready toggling
    base = popped;
    tog = 1'b1;
    for (int n = 0; n < 8; n++) begin
      set_ins(5'(10 + n), 5'(20 + n), 5'(n), 32'(n * 3));
      rf_m[20 + n] = 32'hA000 + 32'(n);
      for (int t = 0; t < 10; t++) begin
        i_ready = tog; tog = ~tog;
        cyc();
        if (last_acc) break;
      end
      chk("stream_accept", {31'd0, last_acc}, 32'd1);
    end
    idle();
    for (int t = 0; t < 10 && mq.size() != 0; t++) begin
      i_ready = tog; tog = ~tog;
      cyc();
    end
    chk("stream_count", 32'(popped - base), 32'd8);
    i_ready = 1'b1;
    flush_cycle();

    // same-cycle set and clear on x5
    set_ins(5'd5, 5'd0, 5'd0, 32'd1);
    cyc();
    set_ins(5'd5, 5'd0, 5'd0, 32'd2);
    wbv = 1'b1; wbi = 5'd5; wbval = 32'h55;
    cyc();
    chk("setclr_accept", {31'd0, last_acc}, 32'd1);
    chk("setclr_busy5", {31'd0, busy[5]}, 32'd1);
    flush_cycle();

    // x0 handling
    rf_m[0] = 32'hDEAD_BEEF;
    set_ins(5'd0, 5'd0, 5'd0, 32'd0);
    wbv = 1'b1; wbi = 5'd0; wbval = 32'hFFFF;
    cyc();
    chk("x0_accept", {31'd0, last_acc}, 32'd1);
    chk("x0_ops", iss_v1 | iss_v2, 32'd0);
    chk("x0_busy", busy, 32'd0);
    idle();

    // flush with full slot and busy = 0xF0
    for (int r = 4; r < 8; r++) begin
      set_ins(5'(r), 5'd0, 5'd0, 32'd0);
      cyc();
    end
    chk("pre_flush_busy", busy, 32'h0000_00F0);
    set_ins(5'd9, 5'd0, 5'd0, 32'd0);
    i_ready = 1'b0; flush = 1'b1;
    cyc();
    chk("flush_no_accept", {31'd0, last_acc}, 32'd0);
    chk("flush_valid", {31'd0, issued_valid}, 32'd0);
    chk("flush_busy", busy, 32'd0);
    idle(); i_ready = 1'b1;

    // asynchronous reset mid-operation
    set_ins(5'd12, 5'd0, 5'd0, 32'd3);
    i_ready = 1'b0;
    cyc();
    idle();
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("async_rst_valid", {31'd0, issued_valid}, 32'd0);
    chk("async_rst_busy", busy, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // random traffic
    for (int i = 1; i < 32; i++) rf_m[i] = $urandom;
    for (int c = 0; c < 400; c++) begin
      d_valid = 1'($urandom % 2);
      d_rd = 5'($urandom_range(0, 7)); d_rs1 = 5'($urandom_range(0, 7));
      d_rs2 = 5'($urandom_range(0, 7)); d_imm = $urandom;
      d_pc = d_pc + 32'd4; d_op = 8'($urandom);
      i_ready = ($urandom % 4) != 0;
      wbv = ($urandom % 3) == 0; wbi = 5'($urandom_range(0, 7)); wbval = $urandom;
      flush = ($urandom % 40) == 0;
      if ($urandom % 8 == 0) rf_m[$urandom_range(0, 31)] = $urandom;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/issue_stage.md
# issue_stage

Issue stage sitting between the decoder and the execution units. Consumes decoded instructions over a `decoupled` input, reads source operands from the register file and tracks pending destination registers in a 32-entry scoreboard. Drives a registered `decoupled` output carrying fully populated instructions (`rs1_val`/`rs2_val` filled) to the ALU and the other exec units. Clears scoreboard entries from the writeback `exec_result` stream.

## Interface
- No parameters; XLEN fixed at 32, 32 architectural registers, x0 hardwired zero.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `decoded` `decoupled.in` (data: decoded instruction struct): incoming instruction; `rs1_val`/`rs2_val` fields ignored.
- `issued` `decoupled.out` (data: decoded instruction struct): outgoing instruction with operand values filled.
- `rf_rs1_idx` out 5: register-file read address 1 = `decoded.data.rs1`.
- `rf_rs1_val` in 32: combinational read data 1.
- `rf_rs2_idx` out 5: register-file read address 2 = `decoded.data.rs2`.
- `rf_rs2_val` in 32: combinational read data 2.
- `wb_valid` in 1: writeback event this cycle.
- `wb` in `exec_result`: writeback payload; uses `rd_idx`, `rd_val`.
- `flush` in 1: pipeline flush (branch redirect / exception).
- `busy` out 32: scoreboard state, bit i = register i pending; bit 0 always 0.

## Operation
- Output slot: one register (`slot_valid`, `slot_data`); `issued.valid = slot_valid`, `issued.data = slot_data`.
- Slot states: EMPTY -> FULL on accept; FULL -> EMPTY on `issued.ready` with no accept; FULL -> FULL (new data) on drain + accept same cycle; any -> EMPTY on `flush`.
- Writeback bypass: source s is forwarded if `wb_valid && wb.rd_idx == s && s != 0`; value taken is `wb.rd_val`, otherwise `rf_rsN_val`. x0 always reads 0 regardless of inputs.
- Source ready: `s == 0` or `!busy[s]` or forwarded this cycle.
- Hazard stall: either source not ready, or `rd != 0 && busy[rd]` and not cleared by writeback this cycle (WAW).
- Space: `!slot_valid || issued.ready`.
- `decoded.ready = space && !hazard && !flush`; accept = `decoded.valid && decoded.ready`.
- On accept: `slot_data` = input with `rs1_val`/`rs2_val` replaced by resolved operands; `busy[rd]` set if `rd != 0`.
- On `wb_valid` with `wb.rd_idx != 0`: clear `busy[wb.rd_idx]`.
- Set and clear of same bit in one cycle: set wins.
- Writeback to a non-busy register: no effect on scoreboard, still forwarded if matching.
- `flush`: slot -> EMPTY, all busy bits cleared, no accept that cycle; takes priority over every other event.
- `decoded.ready` never depends on `decoded.valid`; `issued.data` stable while `issued.valid && !issued.ready`.

## Timing
- Reset: `slot_valid = 0`, `slot_data = 0`, `busy = 0`; hence `issued.valid = 0`, `decoded.ready = 1` once `rst` deasserts (combinational on state).
- Latency: accept at cycle N -> `issued.valid` high at N+1.
- Throughput: one instruction per cycle with no hazards and `issued.ready` held high.
- Dependent back-to-back: consumer stalls until producer's writeback cycle W; accepted in W via bypass, issued at W+1.
- Reset asserted mid-operation: state cleared immediately (async), in-flight slot contents dropped.

## Test plan
- Reset then `addi x1,x0,5` (rf returns 0): `issued.valid` next cycle, `rs1_val=0`, `busy=32'h2`; `wb_valid`, rd_idx=1 -> `busy=0`.
- `add x3,x1,x2` with `busy[1]=1`: `decoded.ready=0` for 3 cycles; cycle 4 `wb` rd_idx=1 rd_val=0x1234 -> accepted that cycle, `issued.data.rs1_val=0x1234` next cycle.
- Stream of 8 independent ops with `issued.ready` toggling 1,0,1,0: no drops, order preserved, `issued.data` stable during stalls, 8 outputs total.
- Same-cycle set/clear: `busy[5]=1`, accept `rd=5` while `wb` rd_idx=5 -> `busy[5]=1` after edge.
- x0 handling: `wb` to rd_idx=0 with 0xFFFF and `add x0,x0,x0` -> `busy=0`, operands 0, no stall.
- Flush with FULL slot and `busy=32'h0000_00F0`: next cycle `issued.valid=0`, `busy=0`, input not accepted during flush cycle.
